// File: rtl/c_result_writer_if.sv
// Result-segment and C-memory write channels between the systolic array drain,
// the result writer and the memory port.
interface c_result_writer_if #(
  parameter int ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16
);
  localparam int LW = $clog2(ARRAY_WIDTH + 1);

  logic                              res_valid;
  logic                              res_ready;
  logic [ARRAY_WIDTH*DATA_WIDTH-1:0] res_data;
  logic [ADDR_WIDTH-1:0]             res_addr;
  logic [LW-1:0]                     res_len;

  logic                              mem_req;
  logic                              mem_we;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic                              mem_ack;

  modport master (
    output res_valid, res_data, res_addr, res_len, mem_ack,
    input  res_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  res_valid, res_data, res_addr, res_len, mem_ack,
    output res_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/c_result_writer.sv
// Buffers result-row segments in a small FIFO and serialises each element as a
// single-word write on the C memory req/ack port.
//
// state    | meaning
// ST_IDLE  | no beat in flight; pops the FIFO head (zero-length heads are dropped)
// ST_WRITE | mem_req high, issuing element idx of the working segment
module c_result_writer #(
  parameter int ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  c_result_writer_if.slave     bus,
  input  logic                 clear,
  output logic [31:0]          words_written,
  output logic                 idle
);
  localparam int LW = $clog2(ARRAY_WIDTH + 1);
  localparam int IW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] row_t;
  typedef enum logic {ST_IDLE, ST_WRITE} state_t;

  row_t                  fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [LW-1:0]         fifo_len  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  state_t                state;
  row_t                  cur_row;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LW-1:0]         cur_len;
  logic [IW-1:0]         idx;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  beat;
  logic                  last_elem;
  logic                  head_nz;
  logic [LW-1:0]         len_in;
  logic [IW-1:0]         idx_nxt;

  assign len_in        = (bus.res_len > LW'(ARRAY_WIDTH)) ? LW'(ARRAY_WIDTH) : bus.res_len;
  assign bus.res_ready = reset_n && (count != CW'(FIFO_DEPTH));
  assign push          = bus.res_valid && bus.res_ready;
  assign head_nz       = (count != '0) && (fifo_len[rd_ptr] != '0);
  assign beat          = req_q && bus.mem_ack;
  assign last_elem     = (LW'(idx) + LW'(1)) >= cur_len;
  assign idx_nxt       = idx + IW'(1);

  // A non-empty head chains straight into WRITE so back-to-back segments keep req high.
  always_comb begin
    load = 1'b0;
    pop  = 1'b0;
    if (state == ST_IDLE) begin
      pop  = (count != '0);
      load = head_nz;
    end else if (beat && last_elem) begin
      pop  = head_nz;
      load = head_nz;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.res_data;
      fifo_addr[wr_ptr] <= bus.res_addr;
      fifo_len[wr_ptr]  <= len_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cur_row  <= '0;
      cur_addr <= '0;
      cur_len  <= '0;
      idx      <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (load) begin
      state    <= ST_WRITE;
      cur_row  <= fifo_data[rd_ptr];
      cur_addr <= fifo_addr[rd_ptr];
      cur_len  <= fifo_len[rd_ptr];
      idx      <= '0;
      req_q    <= 1'b1;
      addr_q   <= fifo_addr[rd_ptr];
      wdata_q  <= fifo_data[rd_ptr][0];
    end else if (state == ST_WRITE && beat) begin
      if (!last_elem) begin
        idx     <= idx_nxt;
        addr_q  <= cur_addr + ADDR_WIDTH'(idx_nxt);
        wdata_q <= cur_row[idx_nxt];
      end else begin
        state <= ST_IDLE;
        req_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)   words_written <= '0;
    else if (clear) words_written <= '0;
    else if (beat)  words_written <= words_written + 32'd1;
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign idle          = (state == ST_IDLE) && (count == '0);
endmodule

// File: tb/tb_c_result_writer.sv
// Bench for c_result_writer: vector table, directed corner sequences and a
// randomized run scored against a queue of expected writes.
module tb_c_result_writer;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NW = 16;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    logic [15:0] addr;
    logic [4:0]  len;
    logic [15:0] base;
    int          exp_beats;
    logic [15:0] exp_last_addr;
    logic [15:0] exp_last_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [31:0] words_written;
  logic        idle;

  int          checks = 0;
  int          failures = 0;
  int          ack_mode = 0;
  logic        req_s = 1'b0;

  beat_t       exp_q[$];
  beat_t       mon_b;
  int          exp_words = 0;
  int          beat_cnt = 0;
  logic [15:0] last_addr, last_data, held_addr, held_data;
  bit          held_valid = 0;

  c_result_writer_if #(.ARRAY_WIDTH(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  c_result_writer #(.ARRAY_WIDTH(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .clear(clear),
    .words_written(words_written), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [15:0] a, input logic [4:0] l, input logic [255:0] d);
    logic [15:0][15:0] row;
    beat_t b;
    int n;
    row = d;
    n = (l > 5'd16) ? 16 : int'(l);
    for (int i = 0; i < n; i++) begin
      b.addr = a + 16'(i);
      b.data = row[i[3:0]];
      exp_q.push_back(b);
    end
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    req_s = bus.mem_req;
    chk("words_written", words_written, exp_words);
    if (!reset_n) begin
      exp_q.delete();
      exp_words = 0;
      held_valid = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) model_push(bus.res_addr, bus.res_len, bus.res_data);
      if (bus.mem_req) chk("mem_we_high", bus.mem_we, 1);
      else             chk("mem_we_low", bus.mem_we, 0);
      if (held_valid) begin
        chk("hold_req", bus.mem_req, 1);
        chk("hold_addr", bus.mem_addr, held_addr);
        chk("hold_data", bus.mem_wdata, held_data);
      end
      if (bus.mem_req && bus.mem_ack) begin
        beat_cnt++;
        last_addr = bus.mem_addr;
        last_data = bus.mem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got addr=0x%0h data=0x%0h expected no beat", bus.mem_addr, bus.mem_wdata);
        end else begin
          mon_b = exp_q.pop_front();
          chk("beat_addr", bus.mem_addr, mon_b.addr);
          chk("beat_data", bus.mem_wdata, mon_b.data);
        end
      end
      if (clear) exp_words = 0;
      else if (bus.mem_req && bus.mem_ack) exp_words++;
      held_valid = bus.mem_req && !bus.mem_ack;
      held_addr  = bus.mem_addr;
      held_data  = bus.mem_wdata;
    end
  end

  // Memory acknowledge mock: 0 held low, 1 held high, 2 toggling while req, 3 random.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        0:       bus.mem_ack = 1'b0;
        1:       bus.mem_ack = 1'b1;
        2:       bus.mem_ack = req_s ? ~bus.mem_ack : 1'b0;
        default: bus.mem_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [4:0] l, input logic [15:0] base,
                      input int max_cyc, output bit ok);
    logic [15:0][15:0] row;
    for (int i = 0; i < 16; i++) row[i[3:0]] = base + 16'(i);
    bus.res_addr  = a;
    bus.res_len   = l;
    bus.res_data  = row;
    bus.res_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      smp();
      ok = bus.res_ready;
      tick();
    end
    if (ok) bus.res_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      smp();
      done = idle;
      tick();
    end
    chk("idle_reached", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t vecs[6];
    bit ok, done;
    int rc, acc, b0, b1;
    vecs[0] = '{16'h0100, 5'd16, 16'h1000, 16, 16'h010F, 16'h100F};
    vecs[1] = '{16'hFFFE, 5'd4,  16'h2000, 4,  16'h0001, 16'h2003};
    vecs[2] = '{16'h0040, 5'd0,  16'h3000, 0,  16'h0000, 16'h0000};
    vecs[3] = '{16'h1234, 5'd20, 16'h4000, 16, 16'h1243, 16'h400F};
    vecs[4] = '{16'h0050, 5'd1,  16'h5000, 1,  16'h0050, 16'h5000};
    vecs[5] = '{16'hFFFF, 5'd31, 16'h6000, 16, 16'h000E, 16'h600F};

    reset_n = 1'b0; clear = 1'b0;
    bus.res_valid = 1'b0; bus.res_addr = '0; bus.res_len = '0; bus.res_data = '0;
    repeat (3) tick();
    smp();
    chk("rst_res_ready", bus.res_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_idle", idle, 1);
    chk("rst_words", words_written, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single segment with toggling ack: latency, req duration, completion.
    ack_mode = 2;
    send(16'h0100, 5'd16, 16'h1000, 10, ok);
    chk("single_accept", ok, 1);
    smp();
    chk("lat_n1_req", bus.mem_req, 0);
    tick(); smp();
    chk("lat_n2_req", bus.mem_req, 1);
    chk("lat_n2_addr", bus.mem_addr, 16'h0100);
    chk("lat_n2_data", bus.mem_wdata, 16'h1000);
    rc = 1; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick(); smp();
      if (bus.mem_req) rc++;
      else done = 1;
    end
    chk("single_req_cycles", rc, 32);
    chk("single_idle_after", idle, 1);
    chk("single_words", words_written, 16);
    tick();

    // Vector table with ack held high.
    ack_mode = 1;
    for (int i = 0; i < 6; i++) begin
      b0 = beat_cnt;
      send(vecs[i].addr, vecs[i].len, vecs[i].base, 10, ok);
      chk($sformatf("vec%0d_accept", i), ok, 1);
      wait_idle(100);
      chk($sformatf("vec%0d_beats", i), beat_cnt - b0, vecs[i].exp_beats);
      if (vecs[i].exp_beats != 0) begin
        chk($sformatf("vec%0d_last_addr", i), last_addr, vecs[i].exp_last_addr);
        chk($sformatf("vec%0d_last_data", i), last_data, vecs[i].exp_last_data);
      end
    end

    // Backpressure: ack held low, six segments offered.
    ack_mode = 0;
    clear = 1'b1; tick(); clear = 1'b0;
    acc = 0;
    for (int s = 0; s < 6; s++) begin
      send(16'h0800 + 16'(s * 16), 5'd16, 16'(s * 256), 8, ok);
      if (ok) acc++;
      else break;
    end
    chk("bp_accepted", acc, 5);
    smp();
    chk("bp_res_ready", bus.res_ready, 0);
    tick();
    ack_mode = 1;
    send(16'h0850, 5'd16, 16'h0500, 200, ok);
    chk("bp_last_accept", ok, 1);
    wait_idle(500);
    chk("bp_words", words_written, 96);

    // Length-1 segments back to back: req must stay high across them.
    ack_mode = 0;
    for (int s = 0; s < 3; s++) begin
      send(16'h0900 + 16'(s), 5'd1, 16'hB000 + 16'(s * 16), 10, ok);
      chk("b2b_accept", ok, 1);
    end
    ack_mode = 1;
    rc = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      smp();
      if (bus.mem_req) rc++;
      else done = 1;
      tick();
    end
    chk("b2b_req_cycles", rc, 3);
    wait_idle(50);

    // Clear on a beat cycle.
    send(16'h0500, 5'd4, 16'h8000, 10, ok);
    chk("clr_accept", ok, 1);
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      smp();
      done = bus.mem_req;
      tick();
    end
    chk("clr_req_seen", done, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    smp();
    chk("clr_words_zero", words_written, 0);
    tick(); smp();
    chk("clr_words_one", words_written, 1);
    tick();
    wait_idle(50);

    // Reset after five beats of a segment with two more queued.
    ack_mode = 2;
    b0 = beat_cnt;
    send(16'h0200, 5'd16, 16'h7000, 10, ok); chk("mr_accept0", ok, 1);
    send(16'h0300, 5'd16, 16'h7100, 10, ok); chk("mr_accept1", ok, 1);
    send(16'h0400, 5'd16, 16'h7200, 10, ok); chk("mr_accept2", ok, 1);
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      smp();
      done = (beat_cnt - b0) >= 5;
      tick();
    end
    chk("mr_five_beats", done, 1);
    reset_n = 1'b0;
    smp();
    chk("mr_res_ready_low", bus.res_ready, 0);
    tick();
    reset_n = 1'b1;
    smp();
    chk("mr_req", bus.mem_req, 0);
    chk("mr_idle", idle, 1);
    chk("mr_words", words_written, 0);
    b1 = beat_cnt; rc = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); smp();
      if (bus.mem_req) rc++;
    end
    chk("mr_no_req_after", rc, 0);
    chk("mr_no_beats_after", beat_cnt - b1, 0);
    tick();

    // Randomized traffic against the reference model.
    ack_mode = 3;
    for (int s = 0; s < 40; s++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 7) == 0) begin
        clear = 1'b1; tick(); clear = 1'b0;
      end
      send(16'($urandom), 5'($urandom_range(0, 20)), 16'($urandom), 400, ok);
      chk("rand_accept", ok, 1);
    end
    wait_idle(3000);
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
